// File: rtl/divider_seq.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock.
// Result is {remainder, quotient}, matching the HI/LO layout of the multiplier.
module divider_seq #(
    parameter int          WIDTH = 32,
    parameter logic [5:0]  DIVU  = 6'b011011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [5:0]         Signal,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] rq_q, rq_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               zflag_q, zflag_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    // Partial remainder after the shift keeps the bit shifted out of rq,
    // so the compare against the divisor is one bit wider than the operands.
    logic [WIDTH:0]     t;
    logic [WIDTH:0]     diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rq_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        t       = rq_q[2*WIDTH-1:WIDTH-1];
        diff    = t - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (Signal == DIVU) begin
                    rq_d    = {{WIDTH{1'b0}}, dataA};
                    dvs_d   = dataB;
                    zflag_d = (dataB == '0);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (t >= {1'b0, dvs_q})
                    rq_d = {diff[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b1};
                else
                    rq_d = {t[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = DONE;
            end
            DONE: begin
                dout_d  = rq_q;
                done_d  = 1'b1;
                dz_d    = zflag_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dataOut  = dout_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign div_zero = dz_q;
endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: directed cases plus random pairs against
// a plain-arithmetic reference, checked by an independent monitor on done.
module tb_divider_seq;
    localparam logic [5:0] DIVU = 6'b011011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA, dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        busy, done, div_zero;

    divider_seq dut (
        .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
        .dataOut(dataOut), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] out;
        logic        z;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t        m_e;
    logic [31:0] m_q, m_r;
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                m_e = sbq.pop_front();
                chk("dataOut", dataOut, m_e.out);
                chk("div_zero", {63'd0, div_zero}, {63'd0, m_e.z});
                if (m_e.b != 0) begin
                    m_q = dataOut[31:0];
                    m_r = dataOut[63:32];
                    chk("invariant", {32'd0, m_q} * {32'd0, m_e.b} + {32'd0, m_r}, {32'd0, m_e.a});
                    chk("rem_lt_dvs", {63'd0, (m_r < m_e.b)}, 64'd1);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] out, input logic z);
        exp_t e;
        e.a = a; e.b = b; e.out = out; e.z = z;
        sbq.push_back(e);
    endtask

    // Called at the negedge right after the start edge; returns cycles to done.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) bc++;
            lat++;
            @(negedge clk);
        end
        if (done !== 1'b1) chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] out, input logic z);
        int lat, bc;
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = DIVU;
        push(a, b, out, z);
        @(negedge clk);
        Signal = 6'd0;
        dataA  = $urandom;
        dataB  = $urandom;
        wait_done(lat, bc);
        chk("latency", 64'(lat), 64'd33);
        chk("busy_cycles", 64'(bc), 64'd32);
        @(negedge clk);
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_dataOut"}, dataOut, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd0);
        chk({tag, "_div_zero"}, {63'd0, div_zero}, 64'd0);
    endtask

    initial begin
        int lat, bc, n;
        logic [31:0] a, b;

        reset  = 1'b1;
        Signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset = 1'b0;

        run(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
        run(32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0);
        run(32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFFFFFF_00000001, 1'b0);
        run(32'd3, 32'd10, 64'h00000003_00000000, 1'b0);
        run(32'd0, 32'd5, 64'h00000000_00000000, 1'b0);
        run(32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1);
        run(32'd8, 32'd2, 64'h00000000_00000004, 1'b0);

        // Start request while busy must be ignored, inputs may wander.
        @(negedge clk);
        dataA = 32'd100; dataB = 32'd7; Signal = DIVU;
        push(32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
        @(negedge clk);
        Signal = 6'd0;
        repeat (9) @(negedge clk);
        dataA = 32'd9; dataB = 32'd3; Signal = DIVU;
        @(negedge clk);
        Signal = 6'd0;
        wait_done(lat, bc);
        repeat (40) @(negedge clk);
        chk("no_restart_busy", {63'd0, busy}, 64'd0);

        // Reset mid-operation aborts with no done.
        @(negedge clk);
        dataA = 32'd100; dataB = 32'd7; Signal = DIVU;
        @(negedge clk);
        Signal = 6'd0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("midreset");
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("after_abort_busy", {63'd0, busy}, 64'd0);
        run(32'd50, 32'd5, 64'h00000000_0000000A, 1'b0);

        // Start held high: back-to-back divisions every 34 cycles.
        @(negedge clk);
        dataA = 32'd1000; dataB = 32'd10; Signal = DIVU;
        push(32'd1000, 32'd10, 64'h00000000_00000064, 1'b0);
        push(32'd1000, 32'd10, 64'h00000000_00000064, 1'b0);
        @(negedge clk);
        wait_done(lat, bc);
        @(negedge clk);
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        Signal = 6'd0;
        chk("b2b_spacing", 64'(n), 64'd34);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2, 3:    b = $urandom_range(2, 255);
                4:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'd0;
                1:       a = 32'hFFFF_FFFF;
                2:       a = $urandom_range(0, 1000);
                default: a = $urandom;
            endcase
            run(a, b, model(a, b), (b == 0));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
